div_share_sched: RTL and testbench
==================================

Name: div_share_sched

Overview:
- Scheduler and sequencer that shares one restoring-divider datapath (dividend shift register plus subtractor/comparator) between two requesters.
- Arbitrates round-robin between the requesters and drives the datapath control strobes: operand select, load, shift and subtract-update.
- Samples the datapath comparator each iteration and assembles the quotient internally.
- Returns a per-requester DONE pulse with the quotient valid.

Parameters:
- WIDTH, 5, operand/quotient width and number of divide iterations.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- REQ0  in  1  requester 0 request; level, held until DONE0.
- REQ1  in  1  requester 1 request; level, held until DONE1.
- COMP  in  1  datapath comparator: partial remainder >= divisor.
- OPSEL  out  1  datapath operand mux select (0 = requester 0, 1 = requester 1).
- LOAD  out  1  load dividend/divisor into datapath, clear partial remainder.
- SHIFT  out  1  shift partial remainder/dividend left one bit.
- SU  out  1  write subtractor result into partial remainder.
- BUSY  out  1  high from grant through DONE cycle.
- GNT0  out  1  requester 0 granted (operands must be stable).
- GNT1  out  1  requester 1 granted (operands must be stable).
- DONE0  out  1  one-cycle pulse, Q valid for requester 0.
- DONE1  out  1  one-cycle pulse, Q valid for requester 1.
- Q  out  WIDTH  quotient, held until next LOAD.

Behaviour:
- Single clock CLK. Reset is synchronous, active-low on RST_N.
- Reset values:
  - All strobes, BUSY, GNTx and DONEx are 0.
  - Q = 0, OPSEL = 0.
  - Round-robin pointer favours REQ0.
  - State returns to IDLE.
- Reset asserted mid-operation aborts on the next edge: no DONE, and the datapath is left as is.
- States: IDLE, LOAD, SHIFT, TEST, DONE.
  - IDLE: if any REQ is high, pick the winner and move to LOAD. Winner is the only requester, or on a tie the one not served last. OPSEL is registered to the winner.
  - LOAD (1 cycle): LOAD=1, GNTx=1, BUSY=1, counter=0, Q cleared. Go to SHIFT.
  - SHIFT (1 cycle): SHIFT=1. Go to TEST.
  - TEST (1 cycle): sample COMP.
    - SU=COMP combinationally.
    - Q <= {Q[WIDTH-2:0], COMP}.
    - counter++.
    - If counter == WIDTH-1 before the increment, go to DONE; otherwise go to SHIFT.
  - DONE (1 cycle): DONEx=1 for the granted requester. Flip the round-robin pointer to the other requester. Go to IDLE.
- GNTx is held from LOAD through DONE inclusive.
- Latency: LOAD edge to DONE pulse = 1 + 2*WIDTH + 1 cycles, i.e. 12 for WIDTH=5.
- Requesters must hold their operands while their GNT is high.
- A REQ dropped mid-operation is ignored: the operation completes and DONE still pulses.
- Back-to-back requests: minimum one IDLE cycle between DONE and the next LOAD.
- Strobes are mutually exclusive: at most one of LOAD, SHIFT, SU is high in any cycle.

Optional Feature:
- Macro: DIV_ZERO_CHECK_EN.
- Defined:
  - Adds input DZ (1 bit, selected divisor == 0) and output ERR (1 bit).
  - In LOAD, if DZ=1, the next state is DONE directly.
  - In that case Q = all ones, ERR=1 alongside the DONE pulse, and ERR clears in the following cycle.
  - Latency is 2 cycles.
- Undefined: no DZ/ERR ports; a zero divisor runs the full sequence, and the datapath yields Q = all ones naturally.

Decomposition:
- Package div_pkg: state enum (IDLE, LOAD, SHIFT, TEST, DONE) as 3-bit localparams, and the DIV_LAT constant function of WIDTH.
- Sub-module rr_arb2: 2-way round-robin winner selection, with REQ0/REQ1 and the last-served bit as inputs and the winner as output. The pointer update stays in the parent.

Test Plan:
The bench uses a behavioural restoring-divide datapath model driven by LOAD/SHIFT/SU/OPSEL and supplying COMP.
1. REQ0 with 13/3 -> GNT0 for 12 cycles, DONE0 at cycle 12, Q=4, model remainder=1.
2. REQ0 and REQ1 rising together after reset (requester 0: 20/4, requester 1: 31/5):
   - REQ0 is served first: Q=5 with DONE0.
   - REQ1 is served next after one IDLE cycle: Q=6 with DONE1.
3. REQ1 held continuously while REQ0 pulses repeatedly -> grants alternate 0,1,0,1; neither requester starves.
4. RST_N low during the TEST of iteration 3 -> next edge: IDLE, all outputs 0, no DONE. A fresh REQ0 with 7/7 then gives Q=1.
5. Edge operands 31/1 -> Q=31; 0/5 -> Q=0; the strobe exclusivity assertion holds throughout.
6. With DIV_ZERO_CHECK_EN, 9/0 -> DONE0 two cycles after the grant, Q=31, ERR=1 for one cycle. Without the macro, the same stimulus runs 12 cycles with Q=31.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg -- shared definitions for the shared-divider scheduler.
//   state_t : sequencer states (3-bit encoding)
//   div_lat : cycles from the LOAD cycle through the DONE cycle, inclusive
package div_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_TEST  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // One load cycle, a shift/test pair per quotient bit, one done cycle.
  function automatic int div_lat(input int width);
    return 1 + 2 * width + 1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2 -- two-way round-robin winner selection (combinational).
//   req0, req1 : request levels
//   last       : requester served most recently (0 or 1)
//   win        : selected requester; only meaningful when a request is present
// The pointer itself is owned and updated by the parent.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic win
);

  // On a tie the requester not served last wins; otherwise the lone requester.
  assign win = (req0 && req1) ? ~last : req1;

endmodule

// File: rtl/div_share_sched.sv
// div_share_sched -- sequencer sharing one restoring-divider datapath between
// two requesters, with round-robin arbitration.
//   CLK, RST_N          : clock, synchronous active-low reset
//   REQ0, REQ1          : request levels, held until the matching DONE
//   COMP                : datapath comparator (partial remainder >= divisor)
//   OPSEL               : datapath operand select (0 = requester 0)
//   LOAD, SHIFT, SU     : datapath strobes (load, shift left, subtract-update)
//   BUSY, GNT0, GNT1    : high from the LOAD cycle through the DONE cycle
//   DONE0, DONE1        : one-cycle completion pulses
//   Q                   : quotient, held until the next LOAD
// Optional macro DIV_ZERO_CHECK_EN adds input DZ (selected divisor is zero)
// and output ERR; a zero divisor then skips straight from LOAD to DONE.
module div_share_sched
  import div_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic             COMP,
`ifdef DIV_ZERO_CHECK_EN
  input  logic             DZ,
  output logic             ERR,
`endif
  output logic             OPSEL,
  output logic             LOAD,
  output logic             SHIFT,
  output logic             SU,
  output logic             BUSY,
  output logic             GNT0,
  output logic             GNT1,
  output logic             DONE0,
  output logic             DONE1,
  output logic [WIDTH-1:0] Q
);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   q_reg;
  logic               opsel_reg;
  logic               last_reg;   // requester served most recently
  logic               win;
`ifdef DIV_ZERO_CHECK_EN
  logic               err_reg;
`endif

  rr_arb2 u_arb (
    .req0 (REQ0),
    .req1 (REQ1),
    .last (last_reg),
    .win  (win)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      q_reg     <= '0;
      opsel_reg <= 1'b0;
      last_reg  <= 1'b1;          // so the first tie goes to requester 0
`ifdef DIV_ZERO_CHECK_EN
      err_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (REQ0 || REQ1) opsel_reg <= win;
        end
        ST_LOAD: begin
          cnt_reg <= '0;
`ifdef DIV_ZERO_CHECK_EN
          q_reg   <= DZ ? '1 : '0;
          err_reg <= DZ;
`else
          q_reg   <= '0;
`endif
        end
        ST_TEST: begin
          q_reg   <= {q_reg[WIDTH-2:0], COMP};
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
        ST_DONE: begin
          last_reg <= opsel_reg;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (REQ0 || REQ1) state_next = ST_LOAD;
`ifdef DIV_ZERO_CHECK_EN
      ST_LOAD:  state_next = DZ ? ST_DONE : ST_SHIFT;
`else
      ST_LOAD:  state_next = ST_SHIFT;
`endif
      ST_SHIFT: state_next = ST_TEST;
      // Counter still holds the pre-increment value here.
      ST_TEST:  state_next = (cnt_reg == CNT_W'(WIDTH - 1)) ? ST_DONE : ST_SHIFT;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Outputs decode from the registered state, so reset clears them at once.
  assign OPSEL = opsel_reg;
  assign LOAD  = (state_reg == ST_LOAD);
  assign SHIFT = (state_reg == ST_SHIFT);
  assign SU    = (state_reg == ST_TEST) && COMP;
  assign BUSY  = (state_reg != ST_IDLE);
  assign GNT0  = BUSY && !opsel_reg;
  assign GNT1  = BUSY && opsel_reg;
  assign DONE0 = (state_reg == ST_DONE) && !opsel_reg;
  assign DONE1 = (state_reg == ST_DONE) && opsel_reg;
  assign Q     = q_reg;
`ifdef DIV_ZERO_CHECK_EN
  assign ERR   = (state_reg == ST_DONE) && err_reg;
`endif

endmodule

// File: tb/tb_div_share_sched.sv
// tb_div_share_sched -- bench for div_share_sched with a behavioural
// restoring-divider datapath; quotients, remainders and latencies are
// predicted with plain integer arithmetic.
module tb_div_share_sched;

  localparam int W   = 5;
  localparam int LAT = 1 + 2 * W + 1;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic REQ0 = 1'b0;
  logic REQ1 = 1'b0;
  logic COMP, OPSEL, LOAD, SHIFT, SU, BUSY, GNT0, GNT1, DONE0, DONE1;
  logic [W-1:0] Q;
`ifdef DIV_ZERO_CHECK_EN
  logic DZ, ERR;
`endif

  logic [W-1:0] a0 = '0, b0 = 5'd1, a1 = '0, b1 = 5'd1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  div_share_sched #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .REQ0  (REQ0),
    .REQ1  (REQ1),
    .COMP  (COMP),
`ifdef DIV_ZERO_CHECK_EN
    .DZ    (DZ),
    .ERR   (ERR),
`endif
    .OPSEL (OPSEL),
    .LOAD  (LOAD),
    .SHIFT (SHIFT),
    .SU    (SU),
    .BUSY  (BUSY),
    .GNT0  (GNT0),
    .GNT1  (GNT1),
    .DONE0 (DONE0),
    .DONE1 (DONE1),
    .Q     (Q)
  );

  // Behavioural datapath: partial remainder / dividend shift pair.
  logic [W:0]   rem_m = '0;
  logic [W-1:0] dvd_m = '0;
  logic [W-1:0] dvs_m = '0;

  assign COMP = (rem_m >= {1'b0, dvs_m});
`ifdef DIV_ZERO_CHECK_EN
  assign DZ = ((OPSEL ? b1 : b0) == '0);
`endif

  always @(posedge CLK) begin
    if (LOAD) begin
      dvd_m <= OPSEL ? a1 : a0;
      dvs_m <= OPSEL ? b1 : b0;
      rem_m <= '0;
    end else if (SHIFT) begin
      rem_m <= {rem_m[W-1:0], dvd_m[W-1]};
      dvd_m <= {dvd_m[W-2:0], 1'b0};
    end else if (SU) begin
      rem_m <= rem_m - {1'b0, dvs_m};
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Continuous monitor: per-cycle invariants plus a scoreboard on every DONE.
  initial begin
    int lat = 0;
    int cyc = 0;
    int last_done_cyc = -100;
    int da, db, exp_q, exp_lat;
    bit dz_now;
    forever begin
      @(negedge CLK);
      cyc++;
      if (RST_N) begin
        lat = BUSY ? lat + 1 : 0;
        check("strobe_excl", int'(LOAD) + int'(SHIFT) + int'(SU) <= 1, 1);
        check("gnt_busy", GNT0 | GNT1, BUSY);
        check("gnt_onehot", GNT0 & GNT1, 0);
        if (LOAD) check("idle_gap", (cyc - last_done_cyc) >= 2, 1);
        dz_now = 1'b0;
        if (DONE0 || DONE1) begin
          da = DONE1 ? int'(a1) : int'(a0);
          db = DONE1 ? int'(b1) : int'(b0);
          dz_now = (db == 0);
          exp_q = (db == 0) ? (1 << W) - 1 : da / db;
          exp_lat = LAT;
`ifdef DIV_ZERO_CHECK_EN
          if (db == 0) exp_lat = 2;
`endif
          check("done_onehot", DONE0 & DONE1, 0);
          check("done_gnt", DONE1 ? GNT1 : GNT0, 1);
          check("done_opsel", OPSEL, DONE1);
          check("done_q", Q, exp_q);
          check("done_lat", lat, exp_lat);
          if (db != 0) check("done_rem", rem_m, da % db);
          last_done_cyc = cyc;
          $display("txn req%0d %0d/%0d q=%0d lat=%0d", DONE1 ? 1 : 0, da, db, Q, lat);
        end
`ifdef DIV_ZERO_CHECK_EN
        check("err", ERR, dz_now);
`endif
      end else begin
        lat = 0;
      end
    end
  end

  task automatic wait_done(output int who);
    who = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (DONE0) begin who = 0; break; end
      if (DONE1) begin who = 1; break; end
    end
    if (who < 0) check("timeout_done", 0, 1);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, BUSY, 0);
    check({tag, "_gnt"}, GNT0 | GNT1, 0);
    check({tag, "_done"}, DONE0 | DONE1, 0);
    check({tag, "_strobes"}, LOAD | SHIFT | SU, 0);
    check({tag, "_opsel"}, OPSEL, 0);
    check({tag, "_q"}, Q, 0);
  endtask

  // Single request from requester sel; returns after the idle cycle that follows DONE.
  task automatic run_op(input int sel, input int a, input int b);
    int who;
    if (sel == 0) begin a0 = W'(a); b0 = W'(b); REQ0 = 1'b1; end
    else          begin a1 = W'(a); b1 = W'(b); REQ1 = 1'b1; end
    wait_done(who);
    check("op_who", who, sel);
    check("op_q", Q, (b == 0) ? (1 << W) - 1 : a / b);
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    int who;
    bit seen_load;

    // Reset state
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    check_idle_outputs("rst");
    RST_N = 1'b1;
    @(negedge CLK);

    // 1: single request 13/3
    a0 = 5'd13; b0 = 5'd3; REQ0 = 1'b1;
    wait_done(who);
    check("t1_who", who, 0);
    check("t1_q", Q, 4);
    check("t1_rem", rem_m, 1);
    REQ0 = 1'b0;
    @(negedge CLK);

    // 2: simultaneous requests after reset, requester 0 favoured
    do_reset();
    a0 = 5'd20; b0 = 5'd4; a1 = 5'd31; b1 = 5'd5;
    REQ0 = 1'b1; REQ1 = 1'b1;
    wait_done(who);
    check("t2_first", who, 0);
    check("t2_q0", Q, 5);
    REQ0 = 1'b0;
    wait_done(who);
    check("t2_second", who, 1);
    check("t2_q1", Q, 6);
    REQ1 = 1'b0;
    @(negedge CLK);

    // 3: REQ1 held, REQ0 re-asserted after each of its DONEs -> alternation
    a0 = W'($urandom_range(31)); b0 = W'($urandom_range(31));
    a1 = W'($urandom_range(31)); b1 = W'($urandom_range(31));
    REQ0 = 1'b1; REQ1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_done(who);
      check("t3_order", who, k % 2);
      if (k == 5) begin
        REQ0 = 1'b0; REQ1 = 1'b0;
      end else if (who == 0) begin
        REQ0 = 1'b0;
        @(negedge CLK);
        a0 = W'($urandom_range(31)); b0 = W'($urandom_range(31));
        REQ0 = 1'b1;
      end else begin
        @(negedge CLK);
        a1 = W'($urandom_range(31)); b1 = W'($urandom_range(31));
      end
    end
    @(negedge CLK);

    // 4: reset during the TEST of the third iteration aborts the operation
    a0 = 5'd29; b0 = 5'd3; REQ0 = 1'b1;
    seen_load = 1'b0;
    for (int i = 0; i < 50 && !seen_load; i++) begin
      @(negedge CLK);
      if (LOAD) seen_load = 1'b1;
    end
    check("t4_load_seen", seen_load, 1);
    repeat (6) @(negedge CLK);
    check("t4_busy_before", BUSY, 1);
    check("t4_not_shift", LOAD | SHIFT, 0);
    RST_N = 1'b0;
    REQ0 = 1'b0;
    @(negedge CLK);
    check_idle_outputs("t4_abort");
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("t4_no_done", DONE0 | DONE1, 0);
    end
    RST_N = 1'b1;
    @(negedge CLK);
    run_op(0, 7, 7);
    check("t4_q_fresh", Q, 1);

    // 5: edge operands
    run_op(0, 31, 1);
    run_op(1, 0, 5);

    // 6: zero divisor (early exit only when the check is built in)
    run_op(0, 9, 0);

    // Random single operations on either requester
    for (int k = 0; k < 10; k++) begin
      run_op(int'($urandom_range(1)), int'($urandom_range(31)), int'($urandom_range(31)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
